// File: rtl/apa102_pkg.sv
// Shared constants and FSM state type for the APA102 serializer.
package apa102_pkg;

  localparam int START_FRAME_BITS    = 32;
  localparam int END_FRAME_BASE_BITS = 32;
  localparam int WORD_BITS           = 16;

  typedef enum logic [1:0] {
    ST_START,
    ST_DATA,
    ST_END
  } state_t;

endpackage

// File: rtl/apa102_bit_timer.sv
// APA102 bit-cell timer: clock_out low then high for CLOCK_DIVIDER cycles each.
// bit_advance pulses in the last high cycle; stall parks the cell at the start of its low phase.
module apa102_bit_timer #(
  parameter int CLOCK_DIVIDER = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic clock_out,
  output logic bit_advance
);

  localparam int            CW   = $clog2(2 * CLOCK_DIVIDER);
  localparam logic [CW-1:0] LAST = CW'(2 * CLOCK_DIVIDER - 1);
  localparam logic [CW-1:0] HIGH = CW'(CLOCK_DIVIDER);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (stall || cnt_q == LAST) cnt_d = '0;
  end

  // clock_out is registered from the next count so the pin never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= (cnt_d >= HIGH);
    end
  end

  assign clock_out   = clk_q;
  assign bit_advance = (cnt_q == LAST) && !stall;

endmodule

// File: rtl/apa102_output.sv
// APA102 channel: prefetches frame words over the SRAM request/strobe handshake and shifts
// start/data/end frames continuously; an empty holding register at a word boundary stalls the line.
module apa102_output
  import apa102_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int CLOCK_DIVIDER     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
  input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
  output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  output logic                         read_request,
  input  logic [DATA_BUS_WIDTH-1:0]    read_data,
  input  logic                         read_finished_strobe,
  output logic                         data_out,
  output logic                         clock_out
);

  localparam int AW = ADDRESS_BUS_WIDTH;
  localparam int DW = DATA_BUS_WIDTH;
  localparam int BW = AW + 1;

  state_t        state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [AW-1:0] word_q, word_d, wc_q, wc_d, fetch_q, fetch_d, addr_q, addr_d;
  logic [DW-1:0] shift_q, shift_d, hold_q, hold_d;
  logic          req_q, req_d, hold_vld_q, hold_vld_d, stall_q, stall_d, init_q;
  logic          bit_advance, strobe, need, load, start_entry;
  logic [BW-1:0] end_last;

  apa102_bit_timer #(.CLOCK_DIVIDER(CLOCK_DIVIDER)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall_q),
    .clock_out   (clock_out),
    .bit_advance (bit_advance)
  );

  assign strobe   = read_finished_strobe && req_q;
  assign end_last = BW'(END_FRAME_BASE_BITS - 1) + BW'(wc_q >> 2);

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    word_d      = word_q;
    wc_d        = wc_q;
    fetch_d     = fetch_q;
    addr_d      = addr_q;
    req_d       = req_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    stall_d     = stall_q;
    need        = 1'b0;
    load        = 1'b0;
    start_entry = init_q;

    if (strobe) begin
      hold_d     = read_data;
      hold_vld_d = 1'b1;
      req_d      = 1'b0;
      addr_d     = addr_q + 1'b1;
    end

    if (stall_q) begin
      if (hold_vld_q) begin
        load    = 1'b1;
        stall_d = 1'b0;
      end
    end else if (bit_advance) begin
      bit_d = bit_q + 1'b1;
      case (state_q)
        ST_START: begin
          if (bit_q == BW'(START_FRAME_BITS - 1)) begin
            bit_d = '0;
            if (wc_q == '0) begin
              state_d = ST_END;
              shift_d = '1;
            end else begin
              state_d = ST_DATA;
              word_d  = '0;
              need    = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (bit_q == BW'(WORD_BITS - 1)) begin
            bit_d = '0;
            if (word_q == wc_q - 1'b1) begin
              state_d = ST_END;
              shift_d = '1;
            end else begin
              word_d = word_q + 1'b1;
              need   = 1'b1;
            end
          end else begin
            shift_d = {shift_q[DW-2:0], 1'b0};
          end
        end
        ST_END: begin
          if (bit_q == end_last) begin
            state_d     = ST_START;
            bit_d       = '0;
            shift_d     = '0;
            start_entry = 1'b1;
          end
        end
        default: state_d = ST_START;
      endcase
    end

    // On a word boundary with nothing prefetched, park until the strobe fills the holding register
    if (need) begin
      if (hold_vld_q) load = 1'b1;
      else            stall_d = 1'b1;
    end

    if (load) begin
      shift_d    = hold_q;
      hold_vld_d = 1'b0;
      if (fetch_q != wc_q) begin
        req_d   = 1'b1;
        fetch_d = fetch_q + 1'b1;
      end
    end

    if (start_entry) begin
      wc_d    = word_count;
      addr_d  = start_address;
      req_d   = (word_count != '0);
      fetch_d = (word_count != '0) ? AW'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_START;
      bit_q      <= '0;
      word_q     <= '0;
      wc_q       <= '0;
      fetch_q    <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      stall_q    <= 1'b0;
      init_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      wc_q       <= wc_d;
      fetch_q    <= fetch_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      stall_q    <= stall_d;
      init_q     <= 1'b0;
    end
  end

  assign read_address = addr_q;
  assign read_request = req_q;
  assign data_out     = shift_q[DW-1];

endmodule

// File: tb/tb_apa102_output.sv
// Directed bench for apa102_output: SRAM model with programmable latency, bit-stream capture on clock_out rises.
module tb_apa102_output;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] word_count, start_address, read_address;
  logic        read_request, data_out, clock_out;
  logic [15:0] sram_dat, inj_dat;
  logic        sram_stb, inj_stb;
  wire  [15:0] read_data            = inj_stb ? inj_dat : sram_dat;
  wire         read_finished_strobe = sram_stb | inj_stb;

  apa102_output dut (
    .clk                  (clk),
    .rst                  (rst),
    .word_count           (word_count),
    .start_address        (start_address),
    .read_address         (read_address),
    .read_request         (read_request),
    .read_data            (read_data),
    .read_finished_strobe (read_finished_strobe),
    .data_out             (data_out),
    .clock_out            (clock_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:65535];
  int          lat;
  logic [15:0] reads[$];
  logic        bits[$];
  logic        exp_q[$];
  int          n_checks = 0, n_err = 0;
  int          rel_cyc, first_rise, last_rise, per_min, per_max, hi_min, hi_max, lo_max, dchg_hi;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM: one read at a time, strobe lat cycles after the request is seen; reset cancels it
  initial begin : sram
    logic [15:0] a;
    logic        ok;
    sram_stb = 1'b0;
    sram_dat = '0;
    forever begin
      @(posedge clk); #1;
      if (read_request && !rst) begin
        a  = read_address;
        reads.push_back(a);
        ok = 1'b1;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk); #1;
          if (rst) ok = 1'b0;
        end
        if (ok) begin
          sram_dat = mem[a];
          sram_stb = 1'b1;
          @(posedge clk); #1;
          sram_stb = 1'b0;
        end
      end
    end
  end

  initial begin : mon
    logic prev_ck, prev_d;
    int   run;
    prev_ck = 1'b0; prev_d = 1'b0; run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ck = 1'b0; prev_d = 1'b0; run = 0;
      end else begin
        if (data_out !== prev_d && clock_out) dchg_hi++;
        prev_d = data_out;
        if (clock_out == prev_ck) run++;
        else begin
          if (prev_ck) begin
            if (run < hi_min) hi_min = run;
            if (run > hi_max) hi_max = run;
          end else if (run > lo_max) lo_max = run;
          run = 1;
          if (clock_out) begin
            bits.push_back(data_out);
            if (first_rise < 0) first_rise = cyc;
            if (last_rise >= 0) begin
              if (cyc - last_rise < per_min) per_min = cyc - last_rise;
              if (cyc - last_rise > per_max) per_max = cyc - last_rise;
            end
            last_rise = cyc;
          end
        end
        prev_ck = clock_out;
      end
    end
  end

  task automatic release_rst();
    rst = 1'b0;
    rel_cyc = cyc;
    bits.delete(); reads.delete(); exp_q.delete();
    first_rise = -1; last_rise = -1; per_min = 1000000; per_max = 0;
    hi_min = 1000000; hi_max = 0; lo_max = 0; dchg_hi = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    release_rst();
  endtask

  task automatic add_frame(input int wc, input logic [15:0] st);
    logic [15:0] a, w;
    for (int i = 0; i < 32; i++) exp_q.push_back(1'b0);
    for (int k = 0; k < wc; k++) begin
      a = st + 16'(k);
      w = mem[a];
      for (int b = 15; b >= 0; b--) exp_q.push_back(w[b]);
    end
    for (int i = 0; i < 32 + (wc >> 2); i++) exp_q.push_back(1'b1);
  endtask

  task automatic wait_bits(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (bits.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check({tag, "_len"}, 64'(bits.size() >= n), 1);
  endtask

  task automatic cmp_stream(input string tag, input int n);
    for (int i = 0; i < n; i += 16) begin
      logic [15:0] g, e;
      g = '0; e = '0;
      for (int j = 0; j < 16 && i + j < n; j++) begin
        g = {g[14:0], bits[i+j]};
        e = {e[14:0], exp_q[i+j]};
      end
      check($sformatf("%s_bits[%0d]", tag, i), g, e);
    end
  endtask

  initial begin : stim
    int k;
    rst = 1'b1; inj_stb = 1'b0; inj_dat = '0; lat = 3;
    word_count = 16'd2; start_address = 16'h0010;
    mem[16'h0010] = 16'hE1FF; mem[16'h0011] = 16'h0080;
    mem[16'hFFFF] = 16'h1234; mem[16'h0000] = 16'hCAFE;
    mem[16'h0040] = 16'h8001; mem[16'h0041] = 16'h7FFE;
    mem[16'h0042] = 16'hA5C3; mem[16'h0043] = 16'h3C5A;
    for (int i = 0; i < 8; i++) mem[16'h0020 + 16'(i)] = 16'h1111 * 16'(i + 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_clock_out", clock_out, 0);
    check("rst_read_request", read_request, 0);
    check("rst_read_address", read_address, 0);
    release_rst();

    // Basic two-word frame, twice
    add_frame(2, 16'h0010); add_frame(2, 16'h0010);
    wait_bits("basic", 192, 2500);
    cmp_stream("basic", 192);
    check("basic_nreads", reads.size(), 4);
    check("basic_rd0", reads[0], 16'h0010);
    check("basic_rd1", reads[1], 16'h0011);
    check("basic_rd2", reads[2], 16'h0010);
    check("basic_rd3", reads[3], 16'h0011);
    check("basic_per_min", per_min, 8);
    check("basic_per_max", per_max, 8);
    check("basic_first_rise", first_rise - rel_cyc, 4);
    check("basic_data_stable", dchg_hi, 0);

    // Empty frame
    word_count = 16'd0;
    do_reset();
    add_frame(0, 16'h0010); add_frame(0, 16'h0010);
    wait_bits("empty", 128, 1500);
    cmp_stream("empty", 128);
    check("empty_nreads", reads.size(), 0);

    // Slow SRAM forces stalls at word boundaries
    word_count = 16'd4; start_address = 16'h0040; lat = 150;
    do_reset();
    add_frame(4, 16'h0040);
    wait_bits("slow", 129, 5000);
    cmp_stream("slow", 129);
    check("slow_hi_min", hi_min, 4);
    check("slow_hi_max", hi_max, 4);
    check("slow_stalled", 64'(lo_max > 4), 1);
    check("slow_data_stable", dchg_hi, 0);
    check("slow_nreads", reads.size(), 4);
    check("slow_rd3", reads[3], 16'h0043);

    // Address wrap
    word_count = 16'd2; start_address = 16'hFFFF; lat = 3;
    do_reset();
    add_frame(2, 16'hFFFF);
    wait_bits("wrap", 96, 1500);
    cmp_stream("wrap", 96);
    check("wrap_rd0", reads[0], 16'hFFFF);
    check("wrap_rd1", reads[1], 16'h0000);

    // Reset in DATA with a strobe injected during reset
    start_address = 16'h0010;
    do_reset();
    k = 0;
    while (!(read_request && read_address == 16'h0011) && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check("mid_reach_data", 64'(k < 3000), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_clock_out", clock_out, 0);
    check("mid_rst_read_request", read_request, 0);
    check("mid_rst_read_address", read_address, 0);
    @(posedge clk); #1;
    inj_dat = 16'h0F0F; inj_stb = 1'b1;
    @(posedge clk); #1;
    inj_stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    release_rst();
    add_frame(2, 16'h0010);
    wait_bits("mid", 96, 1500);
    cmp_stream("mid", 96);
    check("mid_rd0", reads[0], 16'h0010);

    // word_count changed while the 8-word frame is in DATA
    word_count = 16'd8; start_address = 16'h0020;
    do_reset();
    wait_bits("chg_arm", 40, 1000);
    word_count = 16'd4;
    add_frame(8, 16'h0020); add_frame(4, 16'h0020);
    wait_bits("chg", 323, 4000);
    cmp_stream("chg", 323);
    check("chg_nreads", reads.size(), 12);
    check("chg_rd7", reads[7], 16'h0027);
    check("chg_rd8", reads[8], 16'h0020);
    check("chg_rd11", reads[11], 16'h0023);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
